// File: rtl/gvp_stream_pkg.sv
// Shared types and constants for the GVP stream packer: markers, FSM states,
// and the per-event snapshot record.
package gvp_stream_pkg;

  localparam int unsigned NUM_SRCS = 16;
  localparam int unsigned SRC_W    = 32;
  localparam int unsigned IDX_W    = $clog2(NUM_SRCS);
  localparam int unsigned SCAN_W   = IDX_W + 1;

  localparam logic [15:0] MRK_DATA = 16'h0001;
  localparam logic [15:0] MRK_HDR  = 16'hFFFE;
  localparam logic [15:0] MRK_END  = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2
  } state_t;

  typedef struct packed {
    logic [1:0]                typ;
    logic [NUM_SRCS-1:0]       mask;
    logic [31:0]               index;
    logic [47:0]               tim;
    logic [NUM_SRCS*SRC_W-1:0] src;
  } snap_t;

  function automatic logic [15:0] marker(input logic [1:0] typ);
    case (typ)
      2'd1:    return MRK_DATA;
      2'd2:    return MRK_HDR;
      default: return MRK_END;
    endcase
  endfunction

  // Data points carry a 2-word header; section headers and end marks carry 4.
  function automatic logic [1:0] last_hdr(input logic [1:0] typ);
    return (typ == 2'd1) ? 2'd1 : 2'd3;
  endfunction

endpackage

// File: rtl/gvp_next_src.sv
// Combinational scanner: lowest set mask bit at or above i_start.
module gvp_next_src #(
  parameter  int unsigned N  = 16,
  localparam int unsigned IW = $clog2(N),
  localparam int unsigned SW = IW + 1
) (
  input  logic [N-1:0]  i_mask,
  input  logic [SW-1:0] i_start,
  output logic [IW-1:0] o_next_idx_c,
  output logic          o_none_c
);

  // Walk downward so the lowest qualifying bit is the one that sticks.
  always_comb begin
    o_next_idx_c = '0;
    o_none_c     = 1'b1;
    for (int k = N - 1; k >= 0; k--) begin
      if (i_mask[k] && (SW'(k) >= i_start)) begin
        o_next_idx_c = IW'(k);
        o_none_c     = 1'b0;
      end
    end
  end

endmodule

// File: rtl/gvp_stream_packer.sv
// Snapshots GVP store events and serialises each into one AXI-Stream packet,
// with a one-deep pending slot and stall back-pressure toward the GVP core.
module gvp_stream_packer
  import gvp_stream_pkg::*;
(
  input  logic                      a_clk,
  input  logic                      reset,
  input  logic [1:0]                store_data,
  input  logic [31:0]               options,
  input  logic [31:0]               index,
  input  logic [47:0]               gvp_time,
  input  logic [NUM_SRCS*SRC_W-1:0] src_data,
  input  logic                      ovr_clear,
  output logic [SRC_W-1:0]          M_AXIS_tdata,
  output logic                      M_AXIS_tvalid,
  input  logic                      M_AXIS_tready,
  output logic                      M_AXIS_tlast,
  output logic                      stall,
  output logic                      overrun,
  output logic [31:0]               pkt_count
);

  state_t             r_state, w_state_nxt;
  snap_t              r_act, r_pend, w_act_nxt, w_pend_nxt, w_snap;
  logic               r_pend_v, w_pend_v_nxt;
  logic [1:0]         r_hw, w_hw_nxt;
  logic [IDX_W-1:0]   r_pos, w_pos_nxt;
  logic [1:0]         r_store_q;
  logic [31:0]        r_index_q;
  logic               w_ev, w_xfer, w_done, w_drop, w_finish;
  logic [SCAN_W-1:0]  w_scan_start;
  logic [IDX_W-1:0]   w_scan_idx;
  logic               w_scan_none;
  logic [SRC_W-1:0]   w_word;
  logic               w_last;
  logic               w_unused_opt;

  assign w_unused_opt = ^options[31:NUM_SRCS];

  // A held store value is the GVP decimation hold, not a new event.
  assign w_ev   = (store_data != 2'd0) &&
                  ((store_data != r_store_q) || (index != r_index_q));
  assign w_snap = '{typ: store_data, mask: options[NUM_SRCS-1:0], index: index,
                    tim: gvp_time, src: src_data};
  assign w_xfer = M_AXIS_tvalid && M_AXIS_tready;
  assign w_done = w_xfer && M_AXIS_tlast;
  assign w_drop = w_ev && r_pend_v;

  assign w_scan_start = (r_state == DATA) ? ({1'b0, r_pos} + SCAN_W'(1)) : '0;

  gvp_next_src #(.N(NUM_SRCS)) u_next_src (
    .i_mask       (r_act.mask),
    .i_start      (w_scan_start),
    .o_next_idx_c (w_scan_idx),
    .o_none_c     (w_scan_none)
  );

  always_ff @(posedge a_clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_act     <= '0;
      r_pend    <= '0;
      r_pend_v  <= 1'b0;
      r_hw      <= '0;
      r_pos     <= '0;
      r_store_q <= '0;
      r_index_q <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_act     <= w_act_nxt;
      r_pend    <= w_pend_nxt;
      r_pend_v  <= w_pend_v_nxt;
      r_hw      <= w_hw_nxt;
      r_pos     <= w_pos_nxt;
      r_store_q <= store_data;
      r_index_q <= index;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_act_nxt    = r_act;
    w_pend_nxt   = r_pend;
    w_pend_v_nxt = r_pend_v;
    w_hw_nxt     = r_hw;
    w_pos_nxt    = r_pos;
    w_finish     = 1'b0;

    if (w_ev && !r_pend_v && (r_state != IDLE)) begin
      w_pend_nxt   = w_snap;
      w_pend_v_nxt = 1'b1;
    end

    case (r_state)
      IDLE: begin
        if (r_pend_v) begin
          w_act_nxt    = r_pend;
          w_pend_v_nxt = 1'b0;
          w_state_nxt  = HDR;
          w_hw_nxt     = '0;
        end else if (w_ev) begin
          w_act_nxt   = w_snap;
          w_state_nxt = HDR;
          w_hw_nxt    = '0;
        end
      end
      HDR: begin
        if (w_xfer) begin
          if (r_hw == last_hdr(r_act.typ)) begin
            if (r_act.mask == '0) begin
              w_finish = 1'b1;
            end else begin
              w_state_nxt = DATA;
              w_pos_nxt   = w_scan_idx;
            end
          end else begin
            w_hw_nxt = r_hw + 2'd1;
          end
        end
      end
      DATA: begin
        if (w_xfer) begin
          if (w_scan_none) w_finish = 1'b1;
          else             w_pos_nxt = w_scan_idx;
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    // End of packet: chain straight into the next snapshot with no bubble.
    if (w_finish) begin
      w_hw_nxt = '0;
      if (r_pend_v) begin
        w_act_nxt    = r_pend;
        w_pend_v_nxt = 1'b0;
        w_state_nxt  = HDR;
      end else if (w_ev) begin
        w_act_nxt    = w_snap;
        w_pend_v_nxt = 1'b0;
        w_state_nxt  = HDR;
      end else begin
        w_state_nxt = IDLE;
      end
    end
  end

  // Word that will be presented once the next state takes effect.
  always_comb begin
    w_word = '0;
    w_last = 1'b0;
    case (w_state_nxt)
      HDR: begin
        case (w_hw_nxt)
          2'd0:    w_word = {marker(w_act_nxt.typ), 16'(w_act_nxt.mask)};
          2'd1:    w_word = w_act_nxt.index;
          2'd2:    w_word = w_act_nxt.tim[31:0];
          default: w_word = {16'h0000, w_act_nxt.tim[47:32]};
        endcase
        w_last = (w_hw_nxt == last_hdr(w_act_nxt.typ)) && (w_act_nxt.mask == '0);
      end
      DATA: begin
        w_word = w_act_nxt.src[w_pos_nxt*SRC_W +: SRC_W];
        w_last = ((w_act_nxt.mask >> w_pos_nxt) >> 1) == '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge a_clk or posedge reset) begin
    if (reset) begin
      M_AXIS_tdata  <= '0;
      M_AXIS_tvalid <= 1'b0;
      M_AXIS_tlast  <= 1'b0;
      stall         <= 1'b0;
      overrun       <= 1'b0;
      pkt_count     <= '0;
    end else begin
      M_AXIS_tdata  <= w_word;
      M_AXIS_tvalid <= (w_state_nxt != IDLE);
      M_AXIS_tlast  <= w_last;
      stall         <= (w_state_nxt != IDLE) || w_pend_v_nxt;
      if (w_drop)         overrun <= 1'b1;
      else if (ovr_clear) overrun <= 1'b0;
      if (w_done) pkt_count <= pkt_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_gvp_stream_packer.sv
// Scoreboard bench for gvp_stream_packer: directed events push expected words,
// a negedge monitor pops and compares every transferred word.
module tb_gvp_stream_packer;

  logic            a_clk = 1'b0;
  logic            reset;
  logic [1:0]      store_data;
  logic [31:0]     options;
  logic [31:0]     index;
  logic [47:0]     gvp_time;
  logic [16*32-1:0] src_data;
  logic            ovr_clear;
  logic [31:0]     M_AXIS_tdata;
  logic            M_AXIS_tvalid;
  logic            M_AXIS_tready;
  logic            M_AXIS_tlast;
  logic            stall;
  logic            overrun;
  logic [31:0]     pkt_count;

  typedef struct {
    logic [31:0] data;
    logic        last;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  logic        prev_v = 1'b0;
  logic        prev_x = 1'b0;
  logic [31:0] prev_d = '0;
  logic        prev_l = 1'b0;

  gvp_stream_packer dut (
    .a_clk         (a_clk),
    .reset         (reset),
    .store_data    (store_data),
    .options       (options),
    .index         (index),
    .gvp_time      (gvp_time),
    .src_data      (src_data),
    .ovr_clear     (ovr_clear),
    .M_AXIS_tdata  (M_AXIS_tdata),
    .M_AXIS_tvalid (M_AXIS_tvalid),
    .M_AXIS_tready (M_AXIS_tready),
    .M_AXIS_tlast  (M_AXIS_tlast),
    .stall         (stall),
    .overrun       (overrun),
    .pkt_count     (pkt_count)
  );

  always #5 a_clk = ~a_clk;

  task automatic tick();
    @(posedge a_clk);
    #1;
  endtask

  task automatic push(input logic [31:0] d, input logic l);
    exp_t e;
    e.data = d;
    e.last = l;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compare transfers against the scoreboard and hold-stability under stall.
  always @(negedge a_clk) begin
    if (reset) begin
      prev_v <= 1'b0;
      prev_x <= 1'b0;
    end else begin
      if (prev_v && !prev_x) begin
        checks++;
        if (!M_AXIS_tvalid || M_AXIS_tdata !== prev_d || M_AXIS_tlast !== prev_l) begin
          errors++;
          $display("FAIL hold_stable: got v=%b d=%h l=%b expected v=1 d=%h l=%b",
                   M_AXIS_tvalid, M_AXIS_tdata, M_AXIS_tlast, prev_d, prev_l);
        end
      end
      if (M_AXIS_tvalid && M_AXIS_tready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_word: got d=%h l=%b expected none", M_AXIS_tdata, M_AXIS_tlast);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (M_AXIS_tdata !== e.data || M_AXIS_tlast !== e.last) begin
            errors++;
            $display("FAIL word: got d=%h l=%b expected d=%h l=%b",
                     M_AXIS_tdata, M_AXIS_tlast, e.data, e.last);
          end
        end
      end
      prev_v <= M_AXIS_tvalid;
      prev_x <= M_AXIS_tvalid && M_AXIS_tready;
      prev_d <= M_AXIS_tdata;
      prev_l <= M_AXIS_tlast;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    reset = 1'b1; store_data = '0; options = '0; index = '0; gvp_time = '0;
    src_data = '0; ovr_clear = 1'b0; M_AXIS_tready = 1'b1;
    tick(); tick();
    @(negedge a_clk);
    chk("rst_tvalid", 32'(M_AXIS_tvalid), 32'd0);
    chk("rst_tdata", M_AXIS_tdata, 32'd0);
    chk("rst_tlast", 32'(M_AXIS_tlast), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_pkt_count", pkt_count, 32'd0);
    tick();
    reset = 1'b0;
    tick();

    // Data point, mask 0x0005
    index = 32'd5; options = 32'h0000_0005;
    src_data[0*32 +: 32] = 32'h11; src_data[2*32 +: 32] = 32'h22;
    store_data = 2'd1;
    push(32'h0001_0005, 1'b0); push(32'd5, 1'b0); push(32'h11, 1'b0); push(32'h22, 1'b1);
    tick();
    store_data = 2'd0;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge a_clk);
      if (stall) n++;
    end
    chk("stall_cycles", 32'(n), 32'd4);
    chk("pkt_count_1", pkt_count, 32'd1);
    tick();

    // Section header, mask 0
    index = 32'd100; options = '0; gvp_time = 48'h0001_0000_0007;
    store_data = 2'd2;
    push(32'hFFFE_0000, 1'b0); push(32'd100, 1'b0); push(32'h7, 1'b0); push(32'h1, 1'b1);
    tick();
    store_data = 2'd0;
    repeat (6) tick();
    chk("pkt_count_2", pkt_count, 32'd2);

    // Held store is one event; index change is another
    index = 32'd5; store_data = 2'd1;
    push(32'h0001_0000, 1'b0); push(32'd5, 1'b1);
    tick();
    repeat (10) tick();
    index = 32'd4;
    push(32'h0001_0000, 1'b0); push(32'd4, 1'b1);
    tick();
    store_data = 2'd0;
    repeat (4) tick();
    chk("pkt_count_hold", pkt_count, 32'd4);

    // Stall mid-packet with a pending event and an overflowing one
    options = 32'h0000_0003; index = 32'd10;
    src_data[0*32 +: 32] = 32'hA0; src_data[1*32 +: 32] = 32'hA1;
    store_data = 2'd1;
    push(32'h0001_0003, 1'b0); push(32'd10, 1'b0); push(32'hA0, 1'b0); push(32'hA1, 1'b1);
    tick();
    store_data = 2'd0;
    src_data[0*32 +: 32] = 32'hDEAD; src_data[1*32 +: 32] = 32'hBEEF;
    tick();
    M_AXIS_tready = 1'b0;
    options = '0; index = 32'd11; gvp_time = 48'h0000_0000_0009; store_data = 2'd2;
    push(32'hFFFE_0000, 1'b0); push(32'd11, 1'b0); push(32'h9, 1'b0); push(32'h0, 1'b1);
    tick();
    store_data = 2'd0;
    tick();
    index = 32'd12; store_data = 2'd3;
    tick();
    store_data = 2'd0;
    repeat (16) tick();
    @(negedge a_clk);
    chk("overrun_set", 32'(overrun), 32'd1);
    chk("stall_held", 32'(stall), 32'd1);
    chk("tdata_held", M_AXIS_tdata, 32'd10);
    tick();
    M_AXIS_tready = 1'b1;
    repeat (10) tick();
    chk("pkt_count_stall", pkt_count, 32'd6);
    chk("overrun_sticky", 32'(overrun), 32'd1);
    ovr_clear = 1'b1;
    tick();
    ovr_clear = 1'b0;
    chk("overrun_clear", 32'(overrun), 32'd0);

    // Back-to-back via pending: tvalid must not drop between packets
    options = 32'h0000_0001; index = 32'd20; src_data[0*32 +: 32] = 32'hD0; store_data = 2'd1;
    push(32'h0001_0001, 1'b0); push(32'd20, 1'b0); push(32'hD0, 1'b1);
    tick();
    options = '0; index = 32'd21; gvp_time = 48'h5; store_data = 2'd2;
    push(32'hFFFE_0000, 1'b0); push(32'd21, 1'b0); push(32'h5, 1'b0); push(32'h0, 1'b1);
    tick();
    store_data = 2'd0;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge a_clk);
      if (!M_AXIS_tvalid) n++;
    end
    chk("no_bubble", 32'(n), 32'd0);
    repeat (3) tick();
    chk("pkt_count_b2b", pkt_count, 32'd8);

    // Reset in DATA abandons the packet
    options = 32'h0000_000F; index = 32'd30; store_data = 2'd1;
    push(32'h0001_000F, 1'b0); push(32'd30, 1'b0);
    tick();
    store_data = 2'd0;
    tick(); tick();
    reset = 1'b1;
    #1;
    chk("rst_mid_tvalid", 32'(M_AXIS_tvalid), 32'd0);
    chk("rst_mid_stall", 32'(stall), 32'd0);
    chk("rst_mid_pkt_count", pkt_count, 32'd0);
    tick();
    reset = 1'b0;
    tick();
    options = 32'h0000_0002; index = 32'd31; src_data[1*32 +: 32] = 32'hB1; store_data = 2'd1;
    push(32'h0001_0002, 1'b0); push(32'd31, 1'b0); push(32'hB1, 1'b1);
    tick();
    store_data = 2'd0;
    repeat (5) tick();
    chk("pkt_count_after_rst", pkt_count, 32'd1);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
